// File: rtl/bmp_loader.sv
// bmp_loader: parses a 24-bit BMP arriving byte by byte over the ioctl
// download port and writes each pixel as a 32-bit word into a line-pitched
// framebuffer through a toggle-handshake SDRAM write port.
//
// Handshake: a write is requested by toggling mem_req with mem_addr and
// mem_data updated on the same edge; it is outstanding while
// mem_req != mem_ack and completes when the memory side makes mem_ack equal
// to mem_req. Address and data are held stable for the whole outstanding
// period. A new pixel completing while a write is outstanding is an overrun.
module bmp_loader #(
  parameter int LINE_SHIFT = 9,
  parameter int MAX_W      = 512,
  parameter int MAX_H      = 312
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [21:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        bmp_valid,
  output logic        bmp_error,
  output logic [9:0]  bmp_width,
  output logic [8:0]  bmp_height
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    PIXELS = 3'd2,
    PAD    = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  localparam logic [15:0] MAX_W16 = 16'(MAX_W);
  localparam logic [15:0] MAX_H16 = 16'(MAX_H);

  state_t      state_q, state_d;
  logic        dl_q, dl_d;
  logic [7:0]  sig0_q, sig0_d, sig1_q, sig1_d;
  logic [23:0] offset_q, offset_d;
  logic [15:0] width_q, width_d, height_q, height_d;
  logic [7:0]  bpp_lo_q, bpp_lo_d;
  logic        checked_q, checked_d;
  logic [15:0] x_q, x_d, row_q, row_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [1:0]  pad_q, pad_d;
  logic [7:0]  b_q, b_d, g_q, g_d;
  logic        mem_req_q, mem_req_d;
  logic [21:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        valid_q, valid_d, error_q, error_d;
  logic [9:0]  bmp_width_q, bmp_width_d;
  logic [8:0]  bmp_height_q, bmp_height_d;

  logic        rise, fall, stb, take, row_done, bad;
  logic [15:0] bpp_full;

  // Next-state and datapath: download edges, header capture, pixel assembly.
  always_comb begin
    state_d      = state_q;
    dl_d         = ioctl_download;
    sig0_d       = sig0_q;
    sig1_d       = sig1_q;
    offset_d     = offset_q;
    width_d      = width_q;
    height_d     = height_q;
    bpp_lo_d     = bpp_lo_q;
    checked_d    = checked_q;
    x_d          = x_q;
    row_d        = row_q;
    byte_idx_d   = byte_idx_q;
    pad_d        = pad_q;
    b_d          = b_q;
    g_d          = g_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    valid_d      = valid_q;
    error_d      = error_q;
    bmp_width_d  = bmp_width_q;
    bmp_height_d = bmp_height_q;
    rise         = ioctl_download & ~dl_q;
    fall         = ~ioctl_download & dl_q;
    stb          = ioctl_wr & ioctl_download;
    take         = 1'b0;
    row_done     = 1'b0;
    bpp_full     = {ioctl_dout, bpp_lo_q};
    bad          = (sig0_q != 8'h42) || (sig1_q != 8'h4D) || (bpp_full != 16'd24) ||
                   (offset_q < 24'd54) || (width_q == 16'd0) || (width_q > MAX_W16) ||
                   (height_q == 16'd0) || (height_q > MAX_H16);

    if (rise) begin
      // A new download restarts everything; a strobe in this cycle is dropped.
      state_d    = HEADER;
      valid_d    = 1'b0;
      error_d    = 1'b0;
      sig0_d     = 8'd0;
      sig1_d     = 8'd0;
      offset_d   = 24'd0;
      width_d    = 16'd0;
      height_d   = 16'd0;
      bpp_lo_d   = 8'd0;
      checked_d  = 1'b0;
      x_d        = 16'd0;
      row_d      = 16'd0;
      byte_idx_d = 2'd0;
      pad_d      = 2'd0;
    end else begin
      case (state_q)
        HEADER: begin
          if (fall) begin
            state_d = ERROR;
            error_d = 1'b1;
          end else if (stb) begin
            if (checked_q && (ioctl_addr == {1'b0, offset_q})) begin
              state_d = PIXELS;
              take    = 1'b1;
            end else begin
              case (ioctl_addr)
                25'd0:  sig0_d            = ioctl_dout;
                25'd1:  sig1_d            = ioctl_dout;
                25'd10: offset_d[7:0]     = ioctl_dout;
                25'd11: offset_d[15:8]    = ioctl_dout;
                25'd12: offset_d[23:16]   = ioctl_dout;
                25'd18: width_d[7:0]      = ioctl_dout;
                25'd19: width_d[15:8]     = ioctl_dout;
                25'd22: height_d[7:0]     = ioctl_dout;
                25'd23: height_d[15:8]    = ioctl_dout;
                25'd28: bpp_lo_d          = ioctl_dout;
                25'd29: begin
                  bmp_width_d  = width_q[9:0];
                  bmp_height_d = height_q[8:0];
                  if (bad) begin
                    state_d = ERROR;
                    error_d = 1'b1;
                  end else begin
                    checked_d = 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        PIXELS: begin
          if (fall) begin
            state_d = ERROR;
            error_d = 1'b1;
          end else if (stb) begin
            take = 1'b1;
          end
        end
        PAD: begin
          if (fall) begin
            state_d = ERROR;
            error_d = 1'b1;
          end else if (stb) begin
            if (pad_q == 2'd1) row_done = 1'b1;
            else pad_d = pad_q - 2'd1;
          end
        end
        DONE: begin
          if (!ioctl_download) valid_d = 1'b1;
        end
        ERROR: error_d = 1'b1;
        default: ;
      endcase
    end

    if (take) begin
      case (byte_idx_q)
        2'd0: begin
          b_d        = ioctl_dout;
          byte_idx_d = 2'd1;
        end
        2'd1: begin
          g_d        = ioctl_dout;
          byte_idx_d = 2'd2;
        end
        default: begin
          byte_idx_d = 2'd0;
          if (mem_req_q != mem_ack) begin
            state_d = ERROR;
            error_d = 1'b1;
          end else begin
            mem_req_d  = ~mem_req_q;
            mem_addr_d = 22'((32'(row_q) << LINE_SHIFT) + 32'(x_q));
            mem_data_d = {8'h00, ioctl_dout, g_q, b_q};
            if (x_q == width_q - 16'd1) begin
              x_d = 16'd0;
              if (width_q[1:0] != 2'd0) begin
                state_d = PAD;
                pad_d   = width_q[1:0];
              end else begin
                row_done = 1'b1;
              end
            end else begin
              x_d = x_q + 16'd1;
            end
          end
        end
      endcase
    end

    if (row_done) begin
      if (row_q == height_q - 16'd1) begin
        state_d = DONE;
      end else begin
        row_d   = row_q + 16'd1;
        state_d = PIXELS;
      end
    end
  end

  // State register; reset samples the live download level so that a held
  // download is not mistaken for a fresh rising edge afterwards.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      dl_q         <= ioctl_download;
      sig0_q       <= 8'd0;
      sig1_q       <= 8'd0;
      offset_q     <= 24'd0;
      width_q      <= 16'd0;
      height_q     <= 16'd0;
      bpp_lo_q     <= 8'd0;
      checked_q    <= 1'b0;
      x_q          <= 16'd0;
      row_q        <= 16'd0;
      byte_idx_q   <= 2'd0;
      pad_q        <= 2'd0;
      b_q          <= 8'd0;
      g_q          <= 8'd0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 22'd0;
      mem_data_q   <= 32'd0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
      bmp_width_q  <= 10'd0;
      bmp_height_q <= 9'd0;
    end else begin
      state_q      <= state_d;
      dl_q         <= dl_d;
      sig0_q       <= sig0_d;
      sig1_q       <= sig1_d;
      offset_q     <= offset_d;
      width_q      <= width_d;
      height_q     <= height_d;
      bpp_lo_q     <= bpp_lo_d;
      checked_q    <= checked_d;
      x_q          <= x_d;
      row_q        <= row_d;
      byte_idx_q   <= byte_idx_d;
      pad_q        <= pad_d;
      b_q          <= b_d;
      g_q          <= g_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      valid_q      <= valid_d;
      error_q      <= error_d;
      bmp_width_q  <= bmp_width_d;
      bmp_height_q <= bmp_height_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign bmp_valid  = valid_q;
  assign bmp_error  = error_q;
  assign bmp_width  = bmp_width_q;
  assign bmp_height = bmp_height_q;

endmodule

// File: tb/tb_bmp_loader.sv
// Bench for bmp_loader: table of whole-file downloads plus hand-written
// sequences for header rejection timing, overrun, truncation and reset.
module tb_bmp_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [21:0] mem_addr;
  logic [31:0] mem_data;
  logic        bmp_valid, bmp_error;
  logic [9:0]  bmp_width;
  logic [8:0]  bmp_height;

  bmp_loader dut (
    .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_data(mem_data), .bmp_valid(bmp_valid), .bmp_error(bmp_error),
    .bmp_width(bmp_width), .bmp_height(bmp_height)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  logic [53:0] exp_q[$];
  logic [53:0] cap = 54'd0;
  logic        prev_req = 1'b0;
  logic        ack_hold = 1'b0;
  int          ack_cnt = 0;
  logic [7:0]  file_b [0:2047];
  int          file_len = 0;

  typedef struct {
    int w; int h; int off; int bpp; bit sig_ok; bit full;
    bit exp_err; bit exp_valid; int exp_w; int exp_h; int exp_reqs;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory-side responder: acknowledges each request three cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_ack = 1'b0;
        ack_cnt = 0;
      end else if ((mem_req !== mem_ack) && !ack_hold) begin
        ack_cnt++;
        if (ack_cnt >= 3) begin
          mem_ack = mem_req;
          ack_cnt = 0;
        end
      end
    end
  end

  // Scoreboard: each request toggle is matched against the expected queue,
  // and address/data are checked for stability while the request is pending.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = mem_req;
      end else if (mem_req !== prev_req) begin
        prev_req = mem_req;
        req_cnt++;
        cap = {mem_addr, mem_data};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req actual=%0h expected=none", {mem_addr, mem_data});
        end else begin
          chk("req_word", {mem_addr, mem_data}, exp_q.pop_front());
        end
      end else if (mem_req !== mem_ack) begin
        chk("hold_stable", {mem_addr, mem_data}, cap);
      end
    end
  end

  // Build a BMP image in file_b; pixel expectations go into exp_q.
  task automatic build(input int w, input int h, input int off, input int bpp,
                       input bit sig_ok, input bit full);
    int rowb, base;
    logic [7:0] bb, gg, rr;
    for (int i = 0; i < 2048; i++) file_b[i] = 8'h00;
    for (int i = 54; i < off; i++) file_b[i] = 8'hEE;
    file_b[0]  = 8'h42;
    file_b[1]  = sig_ok ? 8'h4D : 8'h58;
    file_b[10] = 8'(off);
    file_b[11] = 8'(off >> 8);
    file_b[12] = 8'(off >> 16);
    file_b[18] = 8'(w);
    file_b[19] = 8'(w >> 8);
    file_b[22] = 8'(h);
    file_b[23] = 8'(h >> 8);
    file_b[26] = 8'h01;
    file_b[28] = 8'(bpp);
    file_b[29] = 8'(bpp >> 8);
    rowb = 3 * w + (w % 4);
    if (full) begin
      file_len = off + h * rowb;
      for (int r = 0; r < h; r++) begin
        for (int x = 0; x < w; x++) begin
          bb = 8'(16 * r + x + 1);
          gg = 8'(64 + 3 * x + r);
          rr = 8'(160 ^ (x + 7 * r));
          base = off + r * rowb + 3 * x;
          file_b[base]     = bb;
          file_b[base + 1] = gg;
          file_b[base + 2] = rr;
          exp_q.push_back({22'(r * 512 + x), 8'h00, rr, gg, bb});
        end
        for (int p = 0; p < (w % 4); p++) file_b[off + r * rowb + 3 * w + p] = 8'h55;
      end
    end else begin
      file_len = 60;
    end
  endtask

  // Driver tasks
  task automatic send_byte(input int addr, input logic [7:0] data);
    ioctl_addr = 25'(addr);
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    tick();
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) send_byte(i, file_b[i]);
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mem_req !== mem_ack) && (n < 60)) begin
      tick();
      n++;
    end
    chk("drain_ack", 64'(mem_ack), 64'(mem_req));
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_data"}, 64'(mem_data), 64'd0);
    chk({tag, "_valid"}, 64'(bmp_valid), 64'd0);
    chk({tag, "_error"}, 64'(bmp_error), 64'd0);
    chk({tag, "_width"}, 64'(bmp_width), 64'd0);
    chk({tag, "_height"}, 64'(bmp_height), 64'd0);
    chk({tag, "_state_idle"}, 64'(int'(dut.state_q)), 64'd0);
  endtask

  vec_t vecs[10];
  int   start;

  initial begin
    vecs[0] = '{2, 2, 54, 24, 1'b1, 1'b1, 1'b0, 1'b1, 2, 2, 4};
    vecs[1] = '{3, 1, 138, 24, 1'b1, 1'b1, 1'b0, 1'b1, 3, 1, 3};
    vecs[2] = '{4, 1, 54, 24, 1'b1, 1'b1, 1'b0, 1'b1, 4, 1, 4};
    vecs[3] = '{1, 3, 54, 24, 1'b1, 1'b1, 1'b0, 1'b1, 1, 3, 3};
    vecs[4] = '{2, 2, 54, 32, 1'b1, 1'b0, 1'b1, 1'b0, 2, 2, 0};
    vecs[5] = '{513, 1, 54, 24, 1'b1, 1'b0, 1'b1, 1'b0, 513, 1, 0};
    vecs[6] = '{2, 2, 40, 24, 1'b1, 1'b0, 1'b1, 1'b0, 2, 2, 0};
    vecs[7] = '{2, 0, 54, 24, 1'b1, 1'b0, 1'b1, 1'b0, 2, 0, 0};
    vecs[8] = '{2, 2, 54, 24, 1'b0, 1'b0, 1'b1, 1'b0, 2, 2, 0};
    vecs[9] = '{2, 32770, 54, 24, 1'b1, 1'b0, 1'b1, 1'b0, 2, 2, 0};

    // Reset state
    tick();
    tick();
    check_all_zero("reset");
    @(negedge clk);
    #1 reset = 1'b0;
    tick();

    // Table of whole downloads
    for (int v = 0; v < 10; v++) begin
      build(vecs[v].w, vecs[v].h, vecs[v].off, vecs[v].bpp, vecs[v].sig_ok, vecs[v].full);
      start = req_cnt;
      start_dl();
      send_range(0, file_len);
      drain();
      chk($sformatf("v%0d_valid_before_end", v), 64'(bmp_valid), 64'd0);
      end_dl();
      chk($sformatf("v%0d_valid", v), 64'(bmp_valid), 64'(vecs[v].exp_valid));
      chk($sformatf("v%0d_error", v), 64'(bmp_error), 64'(vecs[v].exp_err));
      chk($sformatf("v%0d_width", v), 64'(bmp_width), 64'(vecs[v].exp_w));
      chk($sformatf("v%0d_height", v), 64'(bmp_height), 64'(vecs[v].exp_h));
      chk($sformatf("v%0d_reqs", v), 64'(req_cnt - start), 64'(vecs[v].exp_reqs));
      chk($sformatf("v%0d_exp_left", v), 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end

    // Rejection lands exactly on the byte at address 29
    build(2, 2, 54, 32, 1'b1, 1'b0);
    start = req_cnt;
    start_dl();
    send_range(0, 29);
    chk("bpp32_err_before_29", 64'(bmp_error), 64'd0);
    send_byte(29, file_b[29]);
    chk("bpp32_err_at_29", 64'(bmp_error), 64'd1);
    chk("bpp32_state_error", 64'(int'(dut.state_q)), 64'd5);
    send_range(30, 60);
    end_dl();
    chk("bpp32_no_req", 64'(req_cnt - start), 64'd0);

    // Overrun: acknowledge withheld while bytes keep arriving
    build(4, 1, 54, 24, 1'b1, 1'b1);
    start = req_cnt;
    ack_hold = 1'b1;
    start_dl();
    send_range(0, 57);
    chk("ovr_first_addr", 64'(mem_addr), 64'd0);
    chk("ovr_first_data", 64'(mem_data), 64'h00A04001);
    chk("ovr_no_err_yet", 64'(bmp_error), 64'd0);
    send_range(57, 60);
    chk("ovr_error", 64'(bmp_error), 64'd1);
    chk("ovr_addr_held", 64'(mem_addr), 64'd0);
    chk("ovr_data_held", 64'(mem_data), 64'h00A04001);
    tick();
    tick();
    ack_hold = 1'b0;
    drain();
    exp_q.delete();
    send_range(60, file_len);
    end_dl();
    chk("ovr_error_hold", 64'(bmp_error), 64'd1);
    chk("ovr_valid", 64'(bmp_valid), 64'd0);
    chk("ovr_reqs", 64'(req_cnt - start), 64'd1);

    // Truncated download after 5 of 8 pixels, then a good file
    build(4, 2, 54, 24, 1'b1, 1'b1);
    start = req_cnt;
    start_dl();
    send_range(0, 54 + 15);
    drain();
    exp_q.delete();
    end_dl();
    chk("trunc_error", 64'(bmp_error), 64'd1);
    chk("trunc_valid", 64'(bmp_valid), 64'd0);
    chk("trunc_reqs", 64'(req_cnt - start), 64'd5);
    build(2, 2, 54, 24, 1'b1, 1'b1);
    start = req_cnt;
    start_dl();
    chk("redl_error_cleared", 64'(bmp_error), 64'd0);
    send_range(0, file_len);
    drain();
    end_dl();
    chk("redl_valid", 64'(bmp_valid), 64'd1);
    chk("redl_reqs", 64'(req_cnt - start), 64'd4);

    // Reset mid-PIXELS, download held high afterwards
    build(2, 2, 54, 24, 1'b1, 1'b1);
    start_dl();
    send_range(0, 58);
    reset = 1'b1;
    tick();
    check_all_zero("midreset");
    @(negedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    start = req_cnt;
    send_range(58, file_len);
    chk("post_reset_idle", 64'(int'(dut.state_q)), 64'd0);
    chk("post_reset_reqs", 64'(req_cnt - start), 64'd0);
    chk("post_reset_valid", 64'(bmp_valid), 64'd0);
    end_dl();
    chk("post_reset_valid_end", 64'(bmp_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bmp_loader.md
BMP_LOADER -- requirements
Module: bmp_loader

Interface
REQ-001 SHALL have parameter LINE_SHIFT, default 9, meaning log2 of framebuffer words per line.
REQ-002 SHALL have parameter MAX_W, default 512, meaning largest accepted image width in pixels.
REQ-003 SHALL have parameter MAX_H, default 312, meaning largest accepted image height in lines.
REQ-004 SHALL have port clk_sys  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port ioctl_download  in  1  file transfer active.
REQ-007 SHALL have port ioctl_wr  in  1  one-cycle byte strobe.
REQ-008 SHALL have port ioctl_addr  in  25  file byte offset of the strobed byte.
REQ-009 SHALL have port ioctl_dout  in  8  file byte.
REQ-010 SHALL have port mem_req  out  1  toggle write request to SDRAM port.
REQ-011 SHALL have port mem_ack  in  1  toggle acknowledge; the request is complete when mem_ack == mem_req.
REQ-012 SHALL have port mem_addr  out  22  32-bit word address.
REQ-013 SHALL have port mem_data  out  32  pixel word {8'h00, R, G, B}.
REQ-014 SHALL have port bmp_valid  out  1  complete valid image stored.
REQ-015 SHALL have port bmp_error  out  1  last file rejected.
REQ-016 SHALL have port bmp_width  out  10  parsed width.
REQ-017 SHALL have port bmp_height  out  9  parsed height.

Function
REQ-018 SHALL have states IDLE, HEADER, PIXELS, PAD, DONE and ERROR.
REQ-019 SHALL enter HEADER from any state on the ioctl_download rising edge, clearing bmp_valid, bmp_error and all counters.
REQ-020 In HEADER, SHALL capture bytes by ioctl_addr: 0/1 signature, 10-12 data offset[23:0], 18-19 width[15:0], 22-23 height[15:0], 28-29 bpp.
REQ-021 On the byte at address 29, SHALL go to ERROR if signature != "BM", bpp != 24, offset < 54, width == 0 or > MAX_W, or height == 0 or > MAX_H (height bit 15 set counts as > MAX_H); otherwise it SHALL stay in HEADER.
REQ-022 SHALL enter PIXELS on the strobe whose ioctl_addr == offset; that byte SHALL be the first pixel byte.
REQ-023 SHALL assemble pixel bytes in B, G, R order; on the R byte the word SHALL be complete.
REQ-024 On pixel completion, SHALL set mem_addr = (row << LINE_SHIFT) + x and mem_data = {8'h00, R, G, B}, and toggle mem_req in the same cycle as the R strobe; outputs SHALL register on the next edge.
REQ-025 SHALL count row from 0 (first file row = bottom line); address wrap beyond 22 bits SHALL be truncated.
REQ-026 mem_addr and mem_data SHALL be held stable until mem_ack == mem_req.
REQ-027 If a pixel completes while a request is still outstanding (mem_req != mem_ack), SHALL go to ERROR (overrun) and drop that pixel.
REQ-028 After pixel x == width-1, SHALL go to PAD when width[1:0] != 0 and skip width[1:0] bytes; otherwise it SHALL go directly to the next row.
REQ-029 When the last row (row == height-1) completes, including its pad, SHALL go to DONE.
REQ-030 In DONE, SHALL ignore further bytes and set bmp_valid=1 on the ioctl_download falling edge, or immediately if download has already ended.
REQ-031 If ioctl_download falls in HEADER, PIXELS or PAD, SHALL go to ERROR (truncated file).
REQ-032 In ERROR, SHALL hold bmp_error=1 and issue no requests until the next download rising edge.
REQ-033 bmp_width and bmp_height SHALL update at the REQ-021 check and hold afterward.
REQ-034 Strobes while ioctl_download=0 SHALL be ignored.
REQ-035 A download rising edge in the same cycle as a strobe SHALL restart parsing and discard the strobe.

Reset
REQ-036 On reset=1 at a clock edge, SHALL return to IDLE with mem_req=0, mem_addr=0, mem_data=0, bmp_valid=0, bmp_error=0, bmp_width=0, bmp_height=0, and all counters zeroed.
REQ-037 Reset SHALL override every other event in the same cycle, including mid-transfer; the SDRAM side is reset alongside, so mem_ack=0 is expected.
REQ-038 After reset, SHALL remain in IDLE until a download rising edge.

Verification
REQ-039 2x2 24-bit BMP, offset 54, ack after 3 cycles -> 4 requests at addresses 0, 1, 512, 513 with correct {00,R,G,B}; 2 pad bytes skipped per row; bmp_valid=1 after download ends; bmp_width=2, bmp_height=2.
REQ-040 Width 3, 1 row, offset 138 -> addresses 0..2, 3 pad bytes skipped, header bytes 54..137 ignored.
REQ-041 bpp=32 or width=513 -> ERROR at address 29, bmp_error=1, mem_req never toggles.
REQ-042 mem_ack withheld for 10 cycles while bytes arrive every 2 cycles -> overrun ERROR on the next pixel completion; mem_addr and mem_data stay stable while pending.
REQ-043 Download dropped after 5 of 8 pixels -> bmp_error=1, bmp_valid=0; a new valid download then completes with bmp_valid=1.
REQ-044 reset asserted mid-PIXELS -> next cycle all outputs 0 and state IDLE; subsequent strobes without a new download edge are ignored.
